// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM pipeline stage: FSM states, access
// size encodings, byte-enable masks and alignment checks.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [7:0] SZ_B = 8'd8;
    localparam logic [7:0] SZ_H = 8'd16;
    localparam logic [7:0] SZ_W = 8'd32;
    localparam logic [7:0] SZ_D = 8'd64;

    // Any size encoding we do not recognise behaves as a doubleword access.
    function automatic logic [7:0] norm_size(input logic [7:0] size);
        case (size)
            SZ_B, SZ_H, SZ_W: return size;
            default:          return SZ_D;
        endcase
    endfunction

    function automatic logic [7:0] be_mask(input logic [7:0] size);
        case (norm_size(size))
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Keeps the offset bits that survive rounding down to the access size.
    function automatic logic [2:0] align_mask(input logic [7:0] size);
        case (norm_size(size))
            SZ_B:    return 3'b111;
            SZ_H:    return 3'b110;
            SZ_W:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] addr, input logic [7:0] size);
        return (addr & ~align_mask(size)) != 3'b000;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load data alignment: selects the addressed lanes of the returned doubleword
// and sign- or zero-extends the result to 64 bits.
module load_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] dresp_data,
    input  logic [2:0]        off,
    input  logic [7:0]        size,
    input  logic              unsign,
    output logic [63:0]       load_val
);

    logic [7:0]  resp_byte [8];
    logic [63:0] shifted;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign resp_byte[gi] = dresp_data[gi*8 +: 8];
            // Byte gi of the right-shifted word; lanes past the top read as zero.
            assign shifted[gi*8 +: 8] = (({1'b0, off} + 4'(gi)) < 4'd8)
                                        ? resp_byte[3'(gi) + off] : 8'h00;
        end
    endgenerate

    always_comb begin
        load_val = shifted;
        case (norm_size(size))
            SZ_B:    load_val = unsign ? {56'd0, shifted[7:0]}
                                       : {{56{shifted[7]}}, shifted[7:0]};
            SZ_H:    load_val = unsign ? {48'd0, shifted[15:0]}
                                       : {{48{shifted[15]}}, shifted[15:0]};
            SZ_W:    load_val = unsign ? {32'd0, shifted[31:0]}
                                       : {{32{shifted[31]}}, shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: passes ALU results to writeback, runs one load/store at
// a time over a valid/ready data port, and stalls execute while it is busy.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_ready,
    input  logic [63:0]       ex_aluresult,
    input  logic [63:0]       ex_rs2,
    input  logic [5:0]        ex_rd,
    input  logic              ex_mem_active,
    input  logic              ex_load,
    input  logic [7:0]        ex_size,
    input  logic              ex_unsign,
    input  logic              ex_wbactive,
    input  logic              ex_ecall,
    output logic              dreq_valid,
    input  logic              dreq_ready,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic              dreq_we,
    output logic [DATA_W-1:0] dreq_wdata,
    output logic [7:0]        dreq_be,
    input  logic              dresp_valid,
    input  logic [DATA_W-1:0] dresp_data,
    output logic              mem_stall,
    output logic [5:0]        fwd_rd,
    output logic [63:0]       fwd_rdval,
    output logic              fwd_wbactive,
    output logic              wb_ready,
    output logic [5:0]        wb_rd,
    output logic [63:0]       wb_val,
    output logic              wb_wbactive,
    output logic              wb_ecall,
    output logic              mem_misalign
);

    state_e state_reg, state_next;

    logic              capture;
    logic              complete;
    logic [2:0]        ex_off;
    logic [63:0]       load_val;

    // Captured memory instruction
    logic [63:0]       cap_addr_reg;
    logic [5:0]        cap_rd_reg;
    logic [2:0]        cap_off_reg;
    logic [7:0]        cap_size_reg;
    logic              cap_unsign_reg;
    logic              cap_load_reg;
    logic              cap_wbactive_reg;
    logic              cap_ecall_reg;
    logic              cap_misalign_reg;

    logic [ADDR_W-1:0] dreq_addr_reg;
    logic              dreq_we_reg;
    logic [DATA_W-1:0] dreq_wdata_reg;
    logic [7:0]        dreq_be_reg;

    logic [5:0]        fwd_rd_reg;
    logic [63:0]       fwd_rdval_reg;
    logic              fwd_wbactive_reg;
    logic              wb_ready_reg;
    logic [5:0]        wb_rd_reg;
    logic [63:0]       wb_val_reg;
    logic              wb_wbactive_reg;
    logic              wb_ecall_reg;
    logic              mem_misalign_reg;

    assign capture  = ex_ready && !mem_stall;
    assign complete = (state_reg == WAIT) && dresp_valid;
    // Misaligned accesses are rounded down to the size boundary before lane selection.
    assign ex_off   = ex_aluresult[2:0] & align_mask(ex_size);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (capture && ex_mem_active) state_next = REQ;
            REQ:     if (dreq_ready)               state_next = WAIT;
            WAIT:    if (dresp_valid)              state_next = IDLE;
            default:                               state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        dreq_valid = 1'b0;
        mem_stall  = 1'b0;
        case (state_reg)
            REQ: begin
                dreq_valid = 1'b1;
                mem_stall  = 1'b1;
            end
            WAIT:    mem_stall = 1'b1;
            default: ;
        endcase
    end

    load_align #(
        .DATA_W(DATA_W)
    ) u_load_align (
        .dresp_data(dresp_data),
        .off       (cap_off_reg),
        .size      (cap_size_reg),
        .unsign    (cap_unsign_reg),
        .load_val  (load_val)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_addr_reg     <= '0;
            cap_rd_reg       <= '0;
            cap_off_reg      <= '0;
            cap_size_reg     <= '0;
            cap_unsign_reg   <= 1'b0;
            cap_load_reg     <= 1'b0;
            cap_wbactive_reg <= 1'b0;
            cap_ecall_reg    <= 1'b0;
            cap_misalign_reg <= 1'b0;
            dreq_addr_reg    <= '0;
            dreq_we_reg      <= 1'b0;
            dreq_wdata_reg   <= '0;
            dreq_be_reg      <= '0;
            fwd_rd_reg       <= '0;
            fwd_rdval_reg    <= '0;
            fwd_wbactive_reg <= 1'b0;
            wb_ready_reg     <= 1'b0;
            wb_rd_reg        <= '0;
            wb_val_reg       <= '0;
            wb_wbactive_reg  <= 1'b0;
            wb_ecall_reg     <= 1'b0;
            mem_misalign_reg <= 1'b0;
        end else begin
            wb_ready_reg     <= 1'b0;
            mem_misalign_reg <= 1'b0;

            if (capture) begin
                cap_addr_reg     <= ex_aluresult;
                cap_rd_reg       <= ex_rd;
                cap_off_reg      <= ex_off;
                cap_size_reg     <= ex_size;
                cap_unsign_reg   <= ex_unsign;
                cap_load_reg     <= ex_load;
                cap_wbactive_reg <= ex_wbactive;
                cap_ecall_reg    <= ex_ecall;
                cap_misalign_reg <= is_misaligned(ex_aluresult[2:0], ex_size);
                fwd_rd_reg       <= ex_rd;

                if (ex_mem_active) begin
                    dreq_addr_reg    <= {ex_aluresult[ADDR_W-1:3], 3'b000};
                    dreq_we_reg      <= !ex_load;
                    dreq_wdata_reg   <= DATA_W'(ex_rs2 << {ex_off, 3'b000});
                    dreq_be_reg      <= be_mask(ex_size) << ex_off;
                    fwd_wbactive_reg <= 1'b0;
                end else begin
                    wb_ready_reg     <= 1'b1;
                    wb_rd_reg        <= ex_rd;
                    wb_val_reg       <= ex_aluresult;
                    wb_wbactive_reg  <= ex_wbactive;
                    wb_ecall_reg     <= ex_ecall;
                    fwd_rdval_reg    <= ex_aluresult;
                    fwd_wbactive_reg <= ex_wbactive;
                end
            end

            // Stores retire their address with writeback disabled.
            if (complete) begin
                wb_ready_reg     <= 1'b1;
                wb_rd_reg        <= cap_rd_reg;
                wb_val_reg       <= cap_load_reg ? load_val : cap_addr_reg;
                wb_wbactive_reg  <= cap_load_reg && cap_wbactive_reg;
                wb_ecall_reg     <= cap_ecall_reg;
                mem_misalign_reg <= cap_misalign_reg;
                fwd_rdval_reg    <= cap_load_reg ? load_val : cap_addr_reg;
                fwd_wbactive_reg <= cap_load_reg && cap_wbactive_reg;
            end
        end
    end

    assign dreq_addr    = dreq_addr_reg;
    assign dreq_we      = dreq_we_reg;
    assign dreq_wdata   = dreq_wdata_reg;
    assign dreq_be      = dreq_be_reg;
    assign fwd_rd       = fwd_rd_reg;
    assign fwd_rdval    = fwd_rdval_reg;
    assign fwd_wbactive = fwd_wbactive_reg;
    assign wb_ready     = wb_ready_reg;
    assign wb_rd        = wb_rd_reg;
    assign wb_val       = wb_val_reg;
    assign wb_wbactive  = wb_wbactive_reg;
    assign wb_ecall     = wb_ecall_reg;
    assign mem_misalign = mem_misalign_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a table of single instructions plus
// back-pressure and reset-during-access sequences.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_ready;
    logic [63:0] ex_aluresult;
    logic [63:0] ex_rs2;
    logic [5:0]  ex_rd;
    logic        ex_mem_active;
    logic        ex_load;
    logic [7:0]  ex_size;
    logic        ex_unsign;
    logic        ex_wbactive;
    logic        ex_ecall;
    logic        dreq_valid;
    logic        dreq_ready;
    logic [63:0] dreq_addr;
    logic        dreq_we;
    logic [63:0] dreq_wdata;
    logic [7:0]  dreq_be;
    logic        dresp_valid;
    logic [63:0] dresp_data;
    logic        mem_stall;
    logic [5:0]  fwd_rd;
    logic [63:0] fwd_rdval;
    logic        fwd_wbactive;
    logic        wb_ready;
    logic [5:0]  wb_rd;
    logic [63:0] wb_val;
    logic        wb_wbactive;
    logic        wb_ecall;
    logic        mem_misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage #(
        .ADDR_W(64),
        .DATA_W(64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_ready     (ex_ready),
        .ex_aluresult (ex_aluresult),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_mem_active(ex_mem_active),
        .ex_load      (ex_load),
        .ex_size      (ex_size),
        .ex_unsign    (ex_unsign),
        .ex_wbactive  (ex_wbactive),
        .ex_ecall     (ex_ecall),
        .dreq_valid   (dreq_valid),
        .dreq_ready   (dreq_ready),
        .dreq_addr    (dreq_addr),
        .dreq_we      (dreq_we),
        .dreq_wdata   (dreq_wdata),
        .dreq_be      (dreq_be),
        .dresp_valid  (dresp_valid),
        .dresp_data   (dresp_data),
        .mem_stall    (mem_stall),
        .fwd_rd       (fwd_rd),
        .fwd_rdval    (fwd_rdval),
        .fwd_wbactive (fwd_wbactive),
        .wb_ready     (wb_ready),
        .wb_rd        (wb_rd),
        .wb_val       (wb_val),
        .wb_wbactive  (wb_wbactive),
        .wb_ecall     (wb_ecall),
        .mem_misalign (mem_misalign)
    );

    typedef struct {
        string       name;
        logic [63:0] alu;
        logic [63:0] rs2;
        logic [5:0]  rd;
        logic        mem;
        logic        load;
        logic [7:0]  size;
        logic        uns;
        logic        wba;
        logic        ecall;
        logic [63:0] resp;
        logic [63:0] e_addr;
        logic [7:0]  e_be;
        logic [63:0] e_wdata;
        logic [63:0] e_val;
        logic        e_wba;
        logic        e_mis;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_ready      = 1'b0;
        ex_aluresult  = '0;
        ex_rs2        = '0;
        ex_rd         = '0;
        ex_mem_active = 1'b0;
        ex_load       = 1'b0;
        ex_size       = '0;
        ex_unsign     = 1'b0;
        ex_wbactive   = 1'b0;
        ex_ecall      = 1'b0;
        dreq_ready    = 1'b0;
        dresp_valid   = 1'b0;
        dresp_data    = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".dreq_valid"}, 64'(dreq_valid), 64'd0);
        chk({tag, ".mem_stall"},  64'(mem_stall),  64'd0);
        chk({tag, ".wb_ready"},   64'(wb_ready),   64'd0);
        chk({tag, ".dreq_addr"},  dreq_addr,       64'd0);
        chk({tag, ".dreq_be"},    64'(dreq_be),    64'd0);
        chk({tag, ".dreq_wdata"}, dreq_wdata,      64'd0);
        chk({tag, ".dreq_we"},    64'(dreq_we),    64'd0);
        chk({tag, ".wb_val"},     wb_val,          64'd0);
        chk({tag, ".wb_rd"},      64'(wb_rd),      64'd0);
        chk({tag, ".wb_wbactive"},64'(wb_wbactive),64'd0);
        chk({tag, ".wb_ecall"},   64'(wb_ecall),   64'd0);
        chk({tag, ".fwd_rd"},     64'(fwd_rd),     64'd0);
        chk({tag, ".fwd_rdval"},  fwd_rdval,       64'd0);
        chk({tag, ".fwd_wbactive"},64'(fwd_wbactive),64'd0);
        chk({tag, ".mem_misalign"},64'(mem_misalign),64'd0);
    endtask

    task automatic drive(input vec_t v);
        ex_ready      = 1'b1;
        ex_aluresult  = v.alu;
        ex_rs2        = v.rs2;
        ex_rd         = v.rd;
        ex_mem_active = v.mem;
        ex_load       = v.load;
        ex_size       = v.size;
        ex_unsign     = v.uns;
        ex_wbactive   = v.wba;
        ex_ecall      = v.ecall;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive(v);
        @(negedge clk);
        ex_ready = 1'b0;
        if (!v.mem) begin
            chk({v.name, ".mem_stall"},   64'(mem_stall),   64'd0);
            chk({v.name, ".wb_ready"},    64'(wb_ready),    64'd1);
            chk({v.name, ".wb_rd"},       64'(wb_rd),       64'(v.rd));
            chk({v.name, ".wb_val"},      wb_val,           v.e_val);
            chk({v.name, ".wb_wbactive"}, 64'(wb_wbactive), 64'(v.e_wba));
            chk({v.name, ".wb_ecall"},    64'(wb_ecall),    64'(v.ecall));
            chk({v.name, ".fwd_rdval"},   fwd_rdval,        v.e_val);
            chk({v.name, ".fwd_wbactive"},64'(fwd_wbactive),64'(v.e_wba));
        end else begin
            chk({v.name, ".req_stall"},   64'(mem_stall),   64'd1);
            chk({v.name, ".dreq_valid"},  64'(dreq_valid),  64'd1);
            chk({v.name, ".dreq_addr"},   dreq_addr,        v.e_addr);
            chk({v.name, ".dreq_be"},     64'(dreq_be),     64'(v.e_be));
            chk({v.name, ".dreq_we"},     64'(dreq_we),     64'(!v.load));
            if (!v.load)
                chk({v.name, ".dreq_wdata"}, dreq_wdata, v.e_wdata);
            chk({v.name, ".fwd_wbactive_pend"}, 64'(fwd_wbactive), 64'd0);
            dreq_ready = 1'b1;
            @(negedge clk);
            dreq_ready = 1'b0;
            chk({v.name, ".wait_valid"},  64'(dreq_valid),  64'd0);
            chk({v.name, ".wait_stall"},  64'(mem_stall),   64'd1);
            chk({v.name, ".wait_wbrdy"},  64'(wb_ready),    64'd0);
            dresp_valid = 1'b1;
            dresp_data  = v.resp;
            @(negedge clk);
            dresp_valid = 1'b0;
            chk({v.name, ".wb_ready"},    64'(wb_ready),    64'd1);
            chk({v.name, ".done_stall"},  64'(mem_stall),   64'd0);
            chk({v.name, ".wb_rd"},       64'(wb_rd),       64'(v.rd));
            chk({v.name, ".wb_val"},      wb_val,           v.e_val);
            chk({v.name, ".wb_wbactive"}, 64'(wb_wbactive), 64'(v.e_wba));
            chk({v.name, ".mem_misalign"},64'(mem_misalign),64'(v.e_mis));
            chk({v.name, ".fwd_rd"},      64'(fwd_rd),      64'(v.rd));
            if (v.load)
                chk({v.name, ".fwd_rdval"}, fwd_rdval, v.e_val);
        end
        $display("vec %-6s alu=%h wb_ready=%0d wb_rd=%0d wb_val=%h misalign=%0d",
                 v.name, v.alu, wb_ready, wb_rd, wb_val, mem_misalign);
        @(negedge clk);
        chk({v.name, ".pulse_end"},    64'(wb_ready),     64'd0);
        chk({v.name, ".misalign_end"}, 64'(mem_misalign), 64'd0);
    endtask

    initial begin
        //          name    alu                     rs2                     rd  mem ld size   uns wba ecl resp                    e_addr           e_be   e_wdata                 e_val                   ewba emis
        vecs[0]  = '{"add",  64'd42,                 64'd0,                  6'd5,  0, 0, 8'd64, 0, 1, 0, 64'd0,                  64'd0,           8'h00, 64'd0,                  64'd42,                 1, 0};
        vecs[1]  = '{"lb",   64'h1003,               64'd0,                  6'd7,  1, 1, 8'd8,  0, 1, 0, 64'h0000_0000_80FF_0000, 64'h1000,        8'h08, 64'd0,                  64'hFFFF_FFFF_FFFF_FF80, 1, 0};
        vecs[2]  = '{"lbu",  64'h1003,               64'd0,                  6'd8,  1, 1, 8'd8,  1, 1, 0, 64'h0000_0000_80FF_0000, 64'h1000,        8'h08, 64'd0,                  64'h80,                 1, 0};
        vecs[3]  = '{"sh",   64'h1006,               64'hABCD,               6'd9,  1, 0, 8'd16, 0, 1, 0, 64'd0,                  64'h1000,        8'hC0, 64'hABCD_0000_0000_0000, 64'h1006,               0, 0};
        vecs[4]  = '{"lwmis",64'h1002,               64'd0,                  6'd10, 1, 1, 8'd32, 0, 1, 0, 64'h1234_5678_8765_4321, 64'h1000,        8'h0F, 64'd0,                  64'hFFFF_FFFF_8765_4321, 1, 1};
        vecs[5]  = '{"lh",   64'h2002,               64'd0,                  6'd11, 1, 1, 8'd16, 0, 1, 0, 64'h0000_0000_7FFE_0000, 64'h2000,        8'h0C, 64'd0,                  64'h7FFE,               1, 0};
        vecs[6]  = '{"ld",   64'h3008,               64'd0,                  6'd12, 1, 1, 8'd64, 0, 1, 0, 64'hDEAD_BEEF_0123_4567, 64'h3008,        8'hFF, 64'd0,                  64'hDEAD_BEEF_0123_4567, 1, 0};
        vecs[7]  = '{"szbad",64'h4004,               64'd0,                  6'd13, 1, 1, 8'd12, 0, 1, 0, 64'h8899_AABB_CCDD_EEFF, 64'h4000,        8'hFF, 64'd0,                  64'h8899_AABB_CCDD_EEFF, 1, 1};
        vecs[8]  = '{"lwu",  64'h5004,               64'd0,                  6'd14, 1, 1, 8'd32, 1, 1, 0, 64'hF000_0001_0000_0000, 64'h5000,        8'hF0, 64'd0,                  64'h0000_0000_F000_0001, 1, 0};
        vecs[9]  = '{"sb",   64'h6005,               64'h1122_3344_5566_7788, 6'd15, 1, 0, 8'd8,  0, 0, 0, 64'd0,                  64'h6000,        8'h20, 64'h6677_8800_0000_0000, 64'h6005,               0, 0};
        vecs[10] = '{"ecall",64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                  6'd0,  0, 0, 8'd64, 0, 0, 1, 64'd0,                  64'd0,           8'h00, 64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, 0, 0};

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

        // Back-pressure: request held three cycles while execute offers another op.
        begin
            int  lat;
            bit  seen;
            vec_t bp;
            bp = '{"bp", 64'h1010, 64'd0, 6'd20, 1, 1, 8'd32, 0, 1, 0,
                   64'h0000_0000_0000_0123, 64'h1010, 8'h0F, 64'd0, 64'h123, 1, 0};
            @(negedge clk);
            drive(bp);
            lat = 0;
            @(negedge clk);
            lat++;
            ex_aluresult  = 64'd99;
            ex_mem_active = 1'b0;
            ex_rd         = 6'd9;
            for (int k = 0; k < 3; k++) begin
                chk("bp.dreq_valid", 64'(dreq_valid), 64'd1);
                chk("bp.dreq_addr",  dreq_addr,       64'h1010);
                chk("bp.dreq_be",    64'(dreq_be),    64'h0F);
                chk("bp.mem_stall",  64'(mem_stall),  64'd1);
                chk("bp.no_capture", 64'(wb_ready),   64'd0);
                @(negedge clk);
                lat++;
            end
            ex_ready   = 1'b0;
            dreq_ready = 1'b1;
            @(negedge clk);
            lat++;
            dreq_ready  = 1'b0;
            dresp_valid = 1'b1;
            dresp_data  = bp.resp;
            seen = 1'b0;
            for (int k = 0; k < 8 && !seen; k++) begin
                @(negedge clk);
                lat++;
                dresp_valid = 1'b0;
                seen = wb_ready;
            end
            chk("bp.timeout", 64'(seen), 64'd1);
            chk("bp.latency", 64'(lat),  64'd6);
            chk("bp.wb_rd",   64'(wb_rd), 64'd20);
            chk("bp.wb_val",  wb_val,     64'h123);
            $display("seq bp latency=%0d wb_rd=%0d wb_val=%h", lat, wb_rd, wb_val);
            @(negedge clk);
        end

        // Reset while waiting for the response, then a stale response arrives.
        begin
            vec_t rw;
            rw = '{"rw", 64'h7008, 64'd0, 6'd21, 1, 1, 8'd64, 0, 1, 0,
                   64'h55, 64'h7008, 8'hFF, 64'd0, 64'h55, 1, 0};
            @(negedge clk);
            drive(rw);
            @(negedge clk);
            ex_ready   = 1'b0;
            dreq_ready = 1'b1;
            @(negedge clk);
            dreq_ready = 1'b0;
            chk("rw.in_wait", 64'(mem_stall), 64'd1);
            reset = 1'b1;
            @(negedge clk);
            reset       = 1'b0;
            dresp_valid = 1'b1;
            dresp_data  = 64'h55;
            @(negedge clk);
            dresp_valid = 1'b0;
            chk_zero("rw");
            @(negedge clk);
            chk("rw.late_wb", 64'(wb_ready), 64'd0);
            $display("seq rw mem_stall=%0d wb_ready=%0d dreq_valid=%0d", mem_stall, wb_ready, dreq_valid);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
